// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - shares the combinational instruction-ROM read port between fetch and load
// Fetch has fixed priority; a saturating starvation counter forces a load grant after MAX_WAIT denials.
module rom_port_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_err,
  input  logic              i_ld_req,
  input  logic [ADDR_W-1:0] i_ld_addr,
  output logic              o_ld_gnt,
  output logic              o_ld_rvalid,
  output logic [DATA_W-1:0] o_ld_rdata,
  output logic              o_ld_err,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]        r_wait_cnt;
  logic              r_if_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_if_err;
  logic              r_ld_rvalid;
  logic [DATA_W-1:0] r_ld_rdata;
  logic              r_ld_err;

  logic              w_ld_win;
  logic              w_if_gnt;
  logic              w_ld_gnt;
  logic [ADDR_W-1:0] w_addr;
  logic              w_misaligned;
  logic [DATA_W-1:0] w_rdata;

  // Load wins when it is alone or has been starved for MAX_WAIT consecutive cycles.
  always_comb begin
    w_ld_win     = i_ld_req & (~i_if_req | (r_wait_cnt == MAX_WAIT_C));
    w_ld_gnt     = w_ld_win;
    w_if_gnt     = i_if_req & ~w_ld_win;
    w_addr       = '0;
    if (w_if_gnt) begin
      w_addr = i_if_addr;
    end else if (w_ld_gnt) begin
      w_addr = i_ld_addr;
    end
    w_misaligned = (w_addr[1:0] != 2'b00);
    w_rdata      = w_misaligned ? '0 : i_rom_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if (!i_ld_req || w_ld_gnt) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != MAX_WAIT_C) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // Response data and error hold between grants; only rvalid pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_if_err    <= 1'b0;
    end else begin
      r_if_rvalid <= w_if_gnt;
      if (w_if_gnt) begin
        r_if_rdata <= w_rdata;
        r_if_err   <= w_misaligned;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ld_rvalid <= 1'b0;
      r_ld_rdata  <= '0;
      r_ld_err    <= 1'b0;
    end else begin
      r_ld_rvalid <= w_ld_gnt;
      if (w_ld_gnt) begin
        r_ld_rdata <= w_rdata;
        r_ld_err   <= w_misaligned;
      end
    end
  end

  assign o_if_gnt    = w_if_gnt;
  assign o_ld_gnt    = w_ld_gnt;
  assign o_rom_addr  = w_addr;
  assign o_if_rvalid = r_if_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_if_err    = r_if_err;
  assign o_ld_rvalid = r_ld_rvalid;
  assign o_ld_rdata  = r_ld_rdata;
  assign o_ld_err    = r_ld_err;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - randomized and directed bench for rom_port_arbiter against a behavioural model
module tb_rom_port_arbiter;

  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_err;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  logic [DATA_W-1:0] rom [0:511];

  int total = 0;
  int bad   = 0;

  rom_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .o_if_gnt   (if_gnt),
    .o_if_rvalid(if_rvalid),
    .o_if_rdata (if_rdata),
    .o_if_err   (if_err),
    .i_ld_req   (ld_req),
    .i_ld_addr  (ld_addr),
    .o_ld_gnt   (ld_gnt),
    .o_ld_rvalid(ld_rvalid),
    .o_ld_rdata (ld_rdata),
    .o_ld_err   (ld_err),
    .o_rom_addr (rom_addr),
    .i_rom_data (rom_data)
  );

  assign rom_data = rom[rom_addr[10:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: a starvation streak plus the response each port owes next cycle.
  int                streak = 0;
  logic              exp_if_v = 1'b0;
  logic              exp_ld_v = 1'b0;
  logic [DATA_W-1:0] exp_if_d = '0;
  logic [DATA_W-1:0] exp_ld_d = '0;
  logic              exp_if_e = 1'b0;
  logic              exp_ld_e = 1'b0;

  always @(negedge clk) begin
    logic              m_ld_g;
    logic              m_if_g;
    logic [ADDR_W-1:0] m_addr;
    if (!rst_n) begin
      check("rst_if_rvalid", if_rvalid, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_if_err", if_err, 0);
      check("rst_ld_rvalid", ld_rvalid, 0);
      check("rst_ld_rdata", ld_rdata, 0);
      check("rst_ld_err", ld_err, 0);
      streak   = 0;
      exp_if_v = 1'b0;
      exp_ld_v = 1'b0;
    end else begin
      check("if_rvalid", if_rvalid, exp_if_v);
      check("ld_rvalid", ld_rvalid, exp_ld_v);
      if (exp_if_v) begin
        check("if_rdata", if_rdata, exp_if_d);
        check("if_err", if_err, exp_if_e);
      end
      if (exp_ld_v) begin
        check("ld_rdata", ld_rdata, exp_ld_d);
        check("ld_err", ld_err, exp_ld_e);
      end
      m_ld_g = ld_req && (!if_req || streak >= MAX_WAIT);
      m_if_g = if_req && !m_ld_g;
      m_addr = m_if_g ? if_addr : (m_ld_g ? ld_addr : '0);
      check("if_gnt", if_gnt, m_if_g);
      check("ld_gnt", ld_gnt, m_ld_g);
      check("rom_addr", rom_addr, m_addr);
      exp_if_v = m_if_g;
      exp_ld_v = m_ld_g;
      if (m_if_g) begin
        exp_if_e = (m_addr % 4) != 0;
        exp_if_d = exp_if_e ? '0 : rom[m_addr / 4];
      end
      if (m_ld_g) begin
        exp_ld_e = (m_addr % 4) != 0;
        exp_ld_d = exp_ld_e ? '0 : rom[m_addr / 4];
      end
      if (ld_req && !m_ld_g) streak = (streak + 1 > MAX_WAIT) ? MAX_WAIT : streak + 1;
      else streak = 0;
    end
  end

  task automatic drive(input logic fr, input logic [ADDR_W-1:0] fa,
                       input logic lr, input logic [ADDR_W-1:0] la);
    @(posedge clk);
    #1;
    if_req  = fr;
    if_addr = fa;
    ld_req  = lr;
    ld_addr = la;
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] pick_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 11'd2044;
    if (r == 1) return 11'(2045 + $urandom_range(0, 2));
    if (r == 2) return 11'($urandom_range(0, 2047));
    return 11'($urandom_range(0, 511) * 4);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] fa;
    logic              gi;
    logic              gl;
    int                nf;
    logic              got;
    int                nrv;

    for (int i = 0; i < 512; i++) rom[i] = $urandom;
    rom[0]  = 32'h10003FB7;
    rom[58] = 32'h00000040;
    rom[59] = 32'h00000079;
    rom[60] = 32'h00000024;

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ld_req = 1'b0; ld_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Single fetch at 0x000
    drive(1, 11'h000, 0, 0);
    check("t1_if_gnt", if_gnt, 1);
    drive(0, 0, 0, 0);
    check("t1_if_rvalid", if_rvalid, 1);
    check("t1_if_rdata", if_rdata, 32'h10003FB7);
    check("t1_if_err", if_err, 0);

    // Back-to-back loads from the 7-segment table
    drive(0, 0, 1, 11'h0E8);
    check("t2_ld_gnt", ld_gnt, 1);
    drive(0, 0, 1, 11'h0EC);
    check("t2_ld_rdata0", ld_rdata, 32'h00000040);
    check("t2_ld_rvalid0", ld_rvalid, 1);
    check("t2_if_rvalid0", if_rvalid, 0);
    drive(0, 0, 0, 0);
    check("t2_ld_rdata1", ld_rdata, 32'h00000079);
    check("t2_ld_rvalid1", ld_rvalid, 1);
    check("t2_if_rvalid1", if_rvalid, 0);

    // Contention: four fetch grants then one forced load grant, repeating
    fa = '0;
    gl = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(1, fa, 1, 11'h0F0);
      if (gl) begin
        check("t3_ld_rvalid", ld_rvalid, 1);
        check("t3_ld_rdata", ld_rdata, 32'h00000024);
      end
      check("t3_ld_gnt", ld_gnt, (k % 5) == 4);
      gl = ld_gnt;
      if (if_gnt) fa = fa + 11'd4;
    end
    drive(0, 0, 0, 0);

    // Misaligned fetch and top-of-ROM load
    drive(1, 11'h002, 0, 0);
    check("t4_if_gnt", if_gnt, 1);
    drive(0, 0, 1, 11'h7FF);
    check("t4_if_rvalid", if_rvalid, 1);
    check("t4_if_err", if_err, 1);
    check("t4_if_rdata", if_rdata, 0);
    check("t4_ld_gnt", ld_gnt, 1);
    drive(0, 0, 0, 0);
    check("t4_ld_rvalid", ld_rvalid, 1);
    check("t4_ld_err", ld_err, 1);
    check("t4_ld_rdata", ld_rdata, 0);

    // Load abandoned after two denials: starvation count restarts from zero
    nrv = 0;
    drive(1, 11'h000, 1, 11'h0F0);
    nrv += int'(ld_rvalid);
    drive(1, 11'h004, 1, 11'h0F0);
    nrv += int'(ld_rvalid);
    drive(1, 11'h008, 0, 0);
    nrv += int'(ld_rvalid);
    drive(1, 11'h00C, 0, 0);
    nrv += int'(ld_rvalid);
    check("t5_no_ld_rvalid", nrv, 0);
    nf  = 0;
    got = 1'b0;
    fa  = 11'h010;
    for (int k = 0; k < 8 && !got; k++) begin
      drive(1, fa, 1, 11'h0F0);
      if (ld_gnt) got = 1'b1;
      else begin
        nf++;
        fa = fa + 11'd4;
      end
    end
    check("t5_load_granted", got, 1);
    check("t5_fetch_run", nf, MAX_WAIT);
    drive(0, 0, 0, 0);

    // Asynchronous reset in the cycle after a fetch grant
    drive(1, 11'h010, 0, 0);
    check("t6_if_gnt", if_gnt, 1);
    drive(0, 0, 0, 0);
    check("t6_pre_rvalid", if_rvalid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_rvalid", if_rvalid, 0);
    check("t6_rst_rdata", if_rdata, 0);
    check("t6_rst_err", if_err, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    check("t6_post_rvalid0", if_rvalid, 0);
    drive(0, 0, 0, 0);
    check("t6_post_rvalid1", if_rvalid, 0);

    // Randomized traffic honoring the hold-until-granted obligation
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); #1;
      gi = if_gnt;
      gl = ld_gnt;
      @(posedge clk); #1;
      if (!if_req || gi) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = pick_addr();
      end
      if (ld_req && !gl && ($urandom_range(0, 15) == 0)) begin
        ld_req = 1'b0;
      end else if (!ld_req || gl) begin
        ld_req  = ($urandom_range(0, 2) != 0);
        ld_addr = pick_addr();
      end
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single combinational instruction-ROM read port (11-bit byte address, 32-bit little-endian word) between two requesters.
- Requester one is the instruction fetch port. Requester two is a data-side load port that reads constant tables stored in ROM, e.g. the 7-segment lookup table at 0x0E8.
- Arbitration uses fixed fetch priority with a starvation counter that guarantees load progress.
- Read data is registered, so each granted request returns its response one cycle after grant.

Parameters:
- ADDR_W, 11, ROM byte-address width.
- DATA_W, 32, ROM word width.
- MAX_WAIT, 4, number of consecutive denied load cycles after which the load port wins arbitration (legal range 1..15).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_if_req  in  1  fetch request; address held stable until granted.
- i_if_addr  in  ADDR_W  fetch byte address.
- o_if_gnt  out  1  fetch granted this cycle (combinational).
- o_if_rvalid  out  1  fetch response valid, one-cycle pulse.
- o_if_rdata  out  DATA_W  fetch response word.
- o_if_err  out  1  fetch response is a misaligned-address error.
- i_ld_req  in  1  load request; address held stable until granted.
- i_ld_addr  in  ADDR_W  load byte address.
- o_ld_gnt  out  1  load granted this cycle (combinational).
- o_ld_rvalid  out  1  load response valid, one-cycle pulse.
- o_ld_rdata  out  DATA_W  load response word.
- o_ld_err  out  1  load response is a misaligned-address error.
- o_rom_addr  out  ADDR_W  address driven to the ROM.
- i_rom_data  in  DATA_W  combinational ROM read word.

Behaviour:
- Reset (i_rst_n=0, asynchronous): all registered outputs are 0, the wait counter is 0, and any in-flight response is discarded. No rvalid is issued in the first cycle after deassertion.
- Grant rules (combinational, at most one grant per cycle):
  - If only one port requests, that port is granted.
  - If both request and wait_cnt < MAX_WAIT, fetch is granted.
  - If both request and wait_cnt == MAX_WAIT, load is granted.
  - If neither requests, no grant is given.
- o_rom_addr equals the granted port's address; it is 0 when there is no grant.
- wait_cnt (4 bits) update:
  - Increments on each cycle with i_ld_req=1 and o_ld_gnt=0, saturating at MAX_WAIT.
  - Clears to 0 on any load grant, or when i_ld_req=0.
- Latency: a grant in cycle N produces rvalid=1 for that port in cycle N+1 only. rdata is registered from i_rom_data at the N→N+1 edge.
- Throughput: back-to-back grants are allowed, one word per cycle total across both ports.
- Misalignment: if the granted address has [1:0] != 0, the grant still occurs and the cycle is consumed. In N+1: rvalid=1, err=1, rdata=0. This also covers the top-of-ROM wrap (addresses 2045..2047).
- Aligned responses always have err=0. Aligned maximum is 2044, so no wrap occurs.
- rdata and err hold their last value when rvalid=0; consumers use them only while rvalid=1.
- Requester obligation: a requester keeps req=1 and its address stable until it sees gnt. Dropping req before gnt is legal; the request is then abandoned, with no response and no error.
- Simultaneous events: a new grant may occur in the same cycle a previous response is presented; each port's rvalid is independent.
- Reset asserted mid-operation: any pending response is lost and the requester must re-issue.

Test Plan:
- Reset then single fetch at 0x000 → o_if_gnt=1 same cycle; next cycle o_if_rvalid=1, o_if_rdata=0x10003FB7, o_if_err=0.
- Single load at 0x0E8, then at 0x0EC next cycle → o_ld_rdata=0x00000040, then 0x00000079 on consecutive cycles; o_if_rvalid stays 0 throughout.
- Both ports requesting continuously, fetch addresses 0,4,8,..., load at 0x0F0, MAX_WAIT=4 → 4 fetch grants, then 1 load grant returning 0x00000024 with wait_cnt cleared, then fetch resumes; pattern repeats.
- Fetch at 0x002 → granted; next cycle o_if_rvalid=1, o_if_err=1, o_if_rdata=0. Load at 0x7FF → o_ld_err=1.
- Load request withdrawn after 2 denied cycles → wait_cnt returns to 0 and no o_ld_rvalid is issued.
- i_rst_n pulsed low asynchronously in the cycle after a fetch grant → o_if_rvalid=0 immediately, no response after release, all outputs 0.
